// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline sequencing, hazard and forwarding control for the 5-stage core
//
// Tracks shadow copies of the decoder control fields through EX/MEM/WB and
// derives from them the stage enables, flushes, load-use bubbles, EX operand
// forward selects and the data-memory request handshake.
//
// Ports:
//   clk, rst_n                 core clock, asynchronous active-low reset
//   id_*                       decoded fields of the instruction currently in ID
//   ex_redirect                EX resolved a taken branch/jump this cycle
//   dmem_ack                   data memory completes the outstanding access
//   pc_en, *_en                PC and pipeline register load enables
//   if_id_flush, id_ex_flush   squash IF/ID, inject bubble into ID/EX
//   fwd_a, fwd_b               EX operand source: 00 regfile, 10 MEM, 01 WB
//   dmem_req                   data memory request
//   stall_cycles               saturating count of non-advancing cycles

module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              ex_redirect,
    input  logic              dmem_ack,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_flush,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              dmem_req,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t state, state_nxt;

    // Shadow pipeline control fields
    logic              ex_v, ex_rw, ex_mr, ex_mw;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic              mem_v, mem_rw, mem_mr, mem_mw;
    logic [REG_AW-1:0] mem_rd;
    logic              wb_v, wb_rw;
    logic [REG_AW-1:0] wb_rd;

    logic mem_access, mem_hold, redirect, load_use;
    logic rs1_hit, rs2_hit;
    logic mem_fwd_ok, wb_fwd_ok;

    assign mem_access = mem_v & (mem_mr | mem_mw);

    // FSM: request is held continuously while waiting for the ack
    always_comb begin
        state_nxt = state;
        dmem_req  = 1'b0;
        case (state)
            RUN: begin
                dmem_req = mem_access;
                if (mem_access && !dmem_ack) state_nxt = MEM_WAIT;
            end
            MEM_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ack) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    assign mem_hold = dmem_req & ~dmem_ack;

    // Redirect and load-use are only acted on when the pipe advances;
    // during a hold EX is frozen and they are re-evaluated later.
    assign rs1_hit  = id_uses_rs1 && (id_rs1_addr == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2_addr == ex_rd);
    assign redirect = ~mem_hold & ex_v & ex_redirect;
    assign load_use = ~mem_hold & ~redirect & id_valid & ex_v & ex_mr &
                      (ex_rd != '0) & (rs1_hit | rs2_hit);

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if (mem_hold) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // Loads in MEM have no data yet, so they are not a MEM forward source
    assign mem_fwd_ok = mem_v & mem_rw & ~mem_mr & (mem_rd != '0);
    assign wb_fwd_ok  = wb_v & wb_rw & (wb_rd != '0);

    assign fwd_a = (mem_fwd_ok && mem_rd == ex_rs1) ? 2'b10 :
                   (wb_fwd_ok  && wb_rd  == ex_rs1) ? 2'b01 : 2'b00;
    assign fwd_b = (mem_fwd_ok && mem_rd == ex_rs2) ? 2'b10 :
                   (wb_fwd_ok  && wb_rd  == ex_rs2) ? 2'b01 : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v   <= 1'b0;
            ex_rs1 <= '0;
            ex_rs2 <= '0;
            ex_rd  <= '0;
            ex_rw  <= 1'b0;
            ex_mr  <= 1'b0;
            ex_mw  <= 1'b0;
            mem_v  <= 1'b0;
            mem_rd <= '0;
            mem_rw <= 1'b0;
            mem_mr <= 1'b0;
            mem_mw <= 1'b0;
            wb_v   <= 1'b0;
            wb_rd  <= '0;
            wb_rw  <= 1'b0;
        end else if (mem_hold) begin
            // WB retires its instruction once; it sees bubbles while frozen
            wb_v <= 1'b0;
        end else begin
            wb_v   <= mem_v;
            wb_rd  <= mem_rd;
            wb_rw  <= mem_rw;
            mem_v  <= ex_v;
            mem_rd <= ex_rd;
            mem_rw <= ex_rw;
            mem_mr <= ex_mr;
            mem_mw <= ex_mw;
            ex_v   <= id_valid & ~redirect & ~load_use;
            ex_rs1 <= id_rs1_addr;
            ex_rs2 <= id_rs2_addr;
            ex_rd  <= id_rd_addr;
            ex_rw  <= id_reg_write;
            ex_mr  <= id_mem_read;
            ex_mw  <= id_mem_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if ((mem_hold || load_use) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int AW    = 5;
    localparam int CW    = 6;
    localparam int SMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, id_uses_rs1, id_uses_rs2;
    logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic          id_reg_write, id_mem_read, id_mem_write;
    logic          ex_redirect, dmem_ack;
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic          ex_mem_en, mem_wb_en, dmem_req;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd_addr(id_rd_addr),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .ex_redirect(ex_redirect), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .dmem_req(dmem_req), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Reference model: an array of in-flight instructions, index 0=EX 1=MEM 2=WB
    typedef struct {
        bit v;
        int rs1, rs2, rd;
        bit rw, mr, mw;
    } instr_t;

    instr_t pipe [3];
    bit     m_wait;
    int     m_stall;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0, 0, 0};
        m_wait  = 0;
        m_stall = 0;
    endtask

    function automatic bit m_req();
        return m_wait || (pipe[1].v && (pipe[1].mr || pipe[1].mw));
    endfunction

    function automatic bit m_hold();
        return m_req() && !dmem_ack;
    endfunction

    function automatic bit m_redir();
        return !m_hold() && pipe[0].v && ex_redirect;
    endfunction

    function automatic bit m_lu();
        bit dep;
        dep = (id_uses_rs1 && int'(id_rs1_addr) == pipe[0].rd) ||
              (id_uses_rs2 && int'(id_rs2_addr) == pipe[0].rd);
        return !m_hold() && !m_redir() && id_valid && pipe[0].v && pipe[0].mr &&
               pipe[0].rd != 0 && dep;
    endfunction

    function automatic int m_fwd(int r);
        if (r == 0) return 0;
        if (pipe[1].v && pipe[1].rw && !pipe[1].mr && pipe[1].rd == r) return 2;
        if (pipe[2].v && pipe[2].rw && pipe[2].rd == r) return 1;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit h, r, l;
        h = m_hold(); r = m_redir(); l = m_lu();
        chk("pc_en",        32'(pc_en),        32'(!h && !l));
        chk("if_id_en",     32'(if_id_en),     32'(!h && !l));
        chk("if_id_flush",  32'(if_id_flush),  32'(r));
        chk("id_ex_en",     32'(id_ex_en),     32'(!h));
        chk("id_ex_flush",  32'(id_ex_flush),  32'(r || l));
        chk("ex_mem_en",    32'(ex_mem_en),    32'(!h));
        chk("mem_wb_en",    32'(mem_wb_en),    32'(!h));
        chk("fwd_a",        32'(fwd_a),        32'(m_fwd(pipe[0].rs1)));
        chk("fwd_b",        32'(fwd_b),        32'(m_fwd(pipe[0].rs2)));
        chk("dmem_req",     32'(dmem_req),     32'(m_req()));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    endtask

    task automatic model_step();
        bit h, r, l;
        h = m_hold(); r = m_redir(); l = m_lu();
        if (h) begin
            pipe[2].v = 0;
            m_wait = 1;
            if (m_stall < SMAX) m_stall++;
        end else begin
            m_wait  = 0;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = '{id_valid && !r && !l, int'(id_rs1_addr), int'(id_rs2_addr),
                        int'(id_rd_addr), id_reg_write, id_mem_read, id_mem_write};
            if (l && m_stall < SMAX) m_stall++;
        end
    endtask

    // Called just after a falling edge with inputs set
    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_id(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                          input int rd, input bit rw, input bit mr, input bit mw);
        id_valid     = v;
        id_rs1_addr  = AW'(rs1);
        id_rs2_addr  = AW'(rs2);
        id_uses_rs1  = u1;
        id_uses_rs2  = u2;
        id_rd_addr   = AW'(rd);
        id_reg_write = rw;
        id_mem_read  = mr;
        id_mem_write = mw;
    endtask

    task automatic idle(input int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    int s0;

    initial begin
        rst_n = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex_redirect = 1'b0;
        dmem_ack    = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        #1;
        chk("rst_pc_en",    32'(pc_en),        32'(1));
        chk("rst_id_ex_en", 32'(id_ex_en),     32'(1));
        chk("rst_flush",    32'({if_id_flush, id_ex_flush}), 32'(0));
        chk("rst_fwd",      32'({fwd_a, fwd_b}), 32'(0));
        chk("rst_req",      32'(dmem_req),     32'(0));
        chk("rst_stall",    32'(stall_cycles), 32'(0));
        idle(1);

        // Load-use: lw x5 then add x7, x5, x6
        set_id(1, 0, 0, 0, 0, 5, 1, 1, 0); tick();
        set_id(1, 5, 6, 1, 1, 7, 1, 0, 0); #1;
        chk("lu_pc_en",    32'(pc_en),       32'(0));
        chk("lu_if_id_en", 32'(if_id_en),    32'(0));
        chk("lu_flush",    32'(id_ex_flush), 32'(1));
        tick();
        chk("lu_stall", 32'(stall_cycles), 32'(1));
        #1;
        chk("lu_zero_wait_req", 32'(dmem_req), 32'(1));
        tick();
        chk("zero_wait_stall", 32'(stall_cycles), 32'(1));
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("lu_fwd_wb", 32'(fwd_a), 32'(2'b01));
        idle(3);

        // Forward priority: MEM beats WB, x0 never matches
        set_id(1, 0, 0, 0, 0, 3, 1, 0, 0); tick();
        set_id(1, 0, 0, 0, 0, 3, 1, 0, 0); tick();
        set_id(1, 3, 3, 1, 1, 8, 1, 0, 0); tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("prio_fwd_a", 32'(fwd_a), 32'(2'b10));
        chk("prio_fwd_b", 32'(fwd_b), 32'(2'b10));
        idle(3);
        set_id(1, 0, 0, 0, 0, 3, 1, 0, 0); tick();
        set_id(1, 0, 0, 0, 0, 0, 1, 0, 0); tick();
        set_id(1, 3, 0, 1, 1, 8, 1, 0, 0); tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("x0_fwd_a", 32'(fwd_a), 32'(2'b01));
        chk("x0_fwd_b", 32'(fwd_b), 32'(2'b00));
        idle(3);

        // Redirect wins over a simultaneous load-use
        set_id(1, 0, 0, 0, 0, 5, 1, 1, 0); tick();
        set_id(1, 5, 0, 1, 0, 7, 1, 0, 0);
        ex_redirect = 1'b1;
        s0 = m_stall;
        #1;
        chk("redir_if_id_flush", 32'(if_id_flush), 32'(1));
        chk("redir_id_ex_flush", 32'(id_ex_flush), 32'(1));
        chk("redir_pc_en",       32'(pc_en),       32'(1));
        tick();
        ex_redirect = 1'b0;
        chk("redir_stall", 32'(stall_cycles), 32'(s0));
        idle(3);

        // Memory wait with a redirect arriving during the hold
        set_id(1, 0, 0, 1, 1, 0, 0, 0, 1); tick();
        set_id(1, 1, 2, 1, 1, 9, 1, 0, 0); tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        s0 = m_stall;
        dmem_ack    = 1'b0;
        ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wait_req",     32'(dmem_req),    32'(1));
            chk("wait_en",      32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(0));
            chk("wait_flush",   32'({if_id_flush, id_ex_flush}), 32'(0));
            tick();
        end
        dmem_ack = 1'b1; #1;
        chk("ack_req",   32'(dmem_req),    32'(1));
        chk("ack_en",    32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(5'h1f));
        chk("ack_flush", 32'(if_id_flush), 32'(1));
        tick();
        ex_redirect = 1'b0; #1;
        chk("post_ack_req", 32'(dmem_req),     32'(0));
        chk("wait_stall",   32'(stall_cycles), 32'(s0 + 3));
        idle(3);

        // Reset in the middle of a memory wait
        set_id(1, 0, 0, 0, 0, 4, 1, 1, 0); tick();
        idle(1);
        dmem_ack = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_req", 32'(dmem_req), 32'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        dmem_ack = 1'b1;
        #1;
        chk("rst2_stall", 32'(stall_cycles), 32'(0));
        chk("rst2_en",    32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(5'h1f));
        chk("rst2_req",   32'(dmem_req),     32'(0));
        idle(1);

        // Randomized traffic against the model (small register space for hazards)
        repeat (1500) begin
            set_id(1'($urandom_range(0, 3) != 0),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0));
            ex_redirect = 1'($urandom_range(0, 7) == 0);
            dmem_ack    = 1'($urandom_range(0, 2) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Consumes the decoder's per-instruction control fields (rs1/rs2/rd addresses, reg_write, mem_read, mem_write) at ID and keeps a shadow copy of them through EX/MEM/WB.
- From these it generates stage enables, flushes, load-use bubbles and EX operand-forward selects.
- Sequences data-memory accesses through a req/ack handshake, freezing the pipe while memory is busy.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_rs1_addr  in  REG_AW  decoded rs1
- id_rs2_addr  in  REG_AW  decoded rs2
- id_uses_rs1  in  1  instruction reads rs1
- id_uses_rs2  in  1  instruction reads rs2
- id_rd_addr  in  REG_AW  decoded rd
- id_reg_write  in  1  decoder reg_write
- id_mem_read  in  1  decoder mem_read
- id_mem_write  in  1  decoder mem_write
- ex_redirect  in  1  EX resolved a taken branch/jump this cycle
- dmem_ack  in  1  data memory completes the access
- pc_en  out  1  PC register update enable
- if_id_en  out  1  IF/ID register load enable
- if_id_flush  out  1  squash IF/ID contents
- id_ex_en  out  1  ID/EX register load enable
- id_ex_flush  out  1  load bubble into ID/EX
- ex_mem_en  out  1  EX/MEM load enable
- mem_wb_en  out  1  MEM/WB load enable
- fwd_a  out  2  EX operand A source: 00 regfile, 10 MEM stage, 01 WB stage
- fwd_b  out  2  same for operand B
- dmem_req  out  1  data memory request
- stall_cycles  out  CNT_W  count of non-advancing cycles

Behaviour:
- Shadow registers:
  - EX: v, rs1, rs2, rd, rw, mr, mw.
  - MEM: v, rd, rw, mr, mw.
  - WB: v, rd, rw.
- FSM states: RUN, MEM_WAIT.
- Reset (async, rst_n=0):
  - All shadow valids = 0, state = RUN, stall_cycles = 0.
  - Resulting outputs: pc_en=1, if_id_en=1, id_ex_en=1, ex_mem_en=1, mem_wb_en=1, flushes=0, fwd=00, dmem_req=0.
- mem_access = mem_v & (mem_mr | mem_mw).
- dmem_req:
  - Asserted in RUN when mem_access.
  - Asserted continuously in MEM_WAIT.
  - Deasserted the cycle after ack is seen.
- mem_hold = dmem_req & ~dmem_ack.
- FSM transitions:
  - RUN -> MEM_WAIT on mem_hold.
  - MEM_WAIT -> RUN on dmem_ack.
  - Zero-wait ack (ack in the same cycle as req in RUN) stays in RUN with no stall.
- While mem_hold:
  - All enables = 0, flushes = 0.
  - Shadow state is frozen, except wb_v <= 0, so WB receives a bubble.
  - ex_redirect and load-use are ignored (EX is frozen, so both are re-evaluated on the advancing cycle).
- Advance cycle (~mem_hold):
  - All enables = 1.
  - Shift: WB <= MEM, MEM <= EX, EX <= ID fields with ex_v = id_valid.
- Redirect (advance cycle & ex_v & ex_redirect):
  - if_id_flush = 1 and id_ex_flush = 1; next ex_v = 0.
  - pc_en = 1.
  - Redirect has priority over load-use.
- Load-use (advance & ~redirect & id_valid & ex_v & ex_mr & ex_rd != 0 & (uses_rs1 & rs1 == ex_rd | uses_rs2 & rs2 == ex_rd)):
  - pc_en = 0, if_id_en = 0, id_ex_flush = 1; next ex_v = 0.
  - MEM and WB still advance.
- Forwarding (combinational, from shadow EX sources):
  - fwd_a = 10 if mem_v & mem_rw & ~mem_mr & mem_rd != 0 & mem_rd == ex_rs1.
  - Else fwd_a = 01 if wb_v & wb_rw & wb_rd != 0 & wb_rd == ex_rs1.
  - Else fwd_a = 00. fwd_b is identical using ex_rs2.
  - MEM has priority over WB. Register x0 never matches.
- stall_cycles:
  - Increments on any cycle with mem_hold or a load-use stall.
  - Saturates at all-ones.
  - Flush-only cycles do not count.
- Reset mid-MEM_WAIT: state returns to RUN, dmem_req drops immediately (async), and the pending access is abandoned.

Test Plan:
- Load-use:
  - Stimulus: lw x5 in EX (mr=1, rd=5), ID add with rs1=5.
  - Required: one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles 0->1.
  - Next cycle: fwd_a=01 once the lw reaches WB.
- Forward priority:
  - Stimulus: MEM rd=3 rw=1 mr=0 and WB rd=3 rw=1, EX rs1=3, rs2=3.
  - Required: fwd_a=10, fwd_b=10.
  - Same with MEM rd=0 -> fwd_a=01.
- Redirect:
  - Stimulus: ex_v=1, ex_redirect=1, simultaneous load-use condition.
  - Required: if_id_flush=1, id_ex_flush=1, pc_en=1, stall_cycles unchanged.
- Memory wait:
  - Stimulus: sw reaches MEM, dmem_ack low for 3 cycles then high.
  - Required: dmem_req high for 4 cycles; all enables 0 for the 3 hold cycles; FSM MEM_WAIT->RUN; stall_cycles +3.
  - Zero-wait ack gives no stall.
- Freeze interaction:
  - Stimulus: ex_redirect=1 during a memory hold.
  - Required: no flush while held; flush occurs on the ack cycle.
- Reset mid-wait:
  - Stimulus: rst_n low during MEM_WAIT.
  - Required: dmem_req=0 asynchronously; after release, all valids 0, stall_cycles=0, enables=1.
